// File: rtl/cpu19_pkg.sv
// -----------------------------------------------------------------------------
// cpu19_pkg -- definitions shared by the cpu19 control path.
//   * Instruction word width and field positions (opcode/rd/rs1/rs2/imm)
//   * Opcode constants for the non-ALU instructions
//   * ALU operation encodings (0000 ADD .. 0111 SHR)
//   * Control FSM state enum and decoded instruction class enum
// -----------------------------------------------------------------------------
package cpu19_pkg;

    localparam int INSTR_W = 19;

    // Instruction field positions
    localparam int OPC_MSB = 18;
    localparam int OPC_LSB = 14;
    localparam int RD_MSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 2;
    localparam int IMM_MSB = 9;
    localparam int IMM_LSB = 0;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    // Opcodes 0x00..0x07 are register-register ALU ops; alu_op = opcode[3:0]
    localparam opcode_t OPC_ADDI = 5'h08;
    localparam opcode_t OPC_LD   = 5'h10;
    localparam opcode_t OPC_ST   = 5'h11;
    localparam opcode_t OPC_BEQ  = 5'h12;
    localparam opcode_t OPC_BNE  = 5'h13;
    localparam opcode_t OPC_JMP  = 5'h14;
    localparam opcode_t OPC_HALT = 5'h1F;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SHL = 4'b0110,
        ALU_SHR = 4'b0111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_BNE  = 3'd4,
        CLS_JMP  = 3'd5,
        CLS_HALT = 3'd6,
        CLS_ILL  = 3'd7
    } op_class_e;

endpackage

// File: rtl/ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// ctrl_fsm_if -- bundle between the control FSM and the datapath / memories.
//   master : the control FSM (drives requests and control strobes)
//   slave  : datapath + memory side (drives instr, acks, zero flag)
// Signals: instr, imem_req/imem_ack, dmem_req/dmem_we/dmem_ack, zero,
//          alu_op, alu_src_imm, ir_load, reg_we, wb_sel_mem, pc_we, pc_src,
//          halted, timeout, and illegal when CTRL_ILLEGAL_TRAP_EN is defined.
// -----------------------------------------------------------------------------
interface ctrl_fsm_if;
    import cpu19_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               imem_req;
    logic               imem_ack;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;
    logic               zero;
    logic [3:0]         alu_op;
    logic               alu_src_imm;
    logic               ir_load;
    logic               reg_we;
    logic               wb_sel_mem;
    logic               pc_we;
    logic               pc_src;
    logic               halted;
    logic               timeout;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic               illegal;
`endif

    modport master (
`ifdef CTRL_ILLEGAL_TRAP_EN
        output illegal,
`endif
        input  instr, imem_ack, dmem_ack, zero,
        output imem_req, dmem_req, dmem_we, alu_op, alu_src_imm, ir_load,
               reg_we, wb_sel_mem, pc_we, pc_src, halted, timeout
    );

    modport slave (
`ifdef CTRL_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        output instr, imem_ack, dmem_ack, zero,
        input  imem_req, dmem_req, dmem_we, alu_op, alu_src_imm, ir_load,
               reg_we, wb_sel_mem, pc_we, pc_src, halted, timeout
    );

endinterface

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode -- combinational opcode -> control word map.
//   opcode      : in  5-bit opcode field
//   alu_op      : out ALU operation
//   alu_src_imm : out ALU operand b from sign-extended immediate
//   op_class    : out instruction class steering the FSM
// Unlisted opcodes are reported as CLS_ILL; the FSM decides what that means.
// -----------------------------------------------------------------------------
module ctrl_decode
    import cpu19_pkg::*;
(
    input  opcode_t   opcode,
    output alu_op_e   alu_op,
    output logic      alu_src_imm,
    output op_class_e op_class
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        op_class    = CLS_ILL;
        if (opcode[4:3] == 2'b00) begin
            alu_op   = alu_op_e'(opcode[3:0]);
            op_class = CLS_ALU;
        end else begin
            case (opcode)
                OPC_ADDI: begin alu_src_imm = 1'b1; op_class = CLS_ALU; end
                OPC_LD:   begin alu_src_imm = 1'b1; op_class = CLS_LD;  end
                OPC_ST:   begin alu_src_imm = 1'b1; op_class = CLS_ST;  end
                OPC_BEQ:  begin alu_op = ALU_SUB;   op_class = CLS_BEQ; end
                OPC_BNE:  begin alu_op = ALU_SUB;   op_class = CLS_BNE; end
                OPC_JMP:  op_class = CLS_JMP;
                OPC_HALT: op_class = CLS_HALT;
                default:  op_class = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_fsm.sv
// -----------------------------------------------------------------------------
// ctrl_fsm -- multi-cycle control FSM for the cpu19 core.
//   clk   : in  clock, rising edge
//   rst_n : in  asynchronous active-low reset
//   bus   : ctrl_fsm_if.master (memory handshakes + datapath control)
// Parameter TIMEOUT_CYCLES: max cycles of unanswered imem/dmem request.
// Macro CTRL_ILLEGAL_TRAP_EN: unlisted opcodes pulse bus.illegal and halt;
// without it they behave as a NOP.
// -----------------------------------------------------------------------------
module ctrl_fsm
    import cpu19_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_fsm_if.master   bus
);

    // The counter never has to hold TIMEOUT_CYCLES itself: the cycle that
    // would take it there either completes or times out and clears it.
    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    state_e              state_q, state_d;
    opcode_t             opcode_q, opcode_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    // Low through reset and until the first clock after release, so every
    // output (including imem_req) stays 0 while rst_n is low.
    logic                run_q, run_d;

    alu_op_e             dec_alu_op;
    logic                dec_src_imm;
    op_class_e           dec_class;
    logic                wait_last;

    ctrl_decode u_decode (
        .opcode      (opcode_q),
        .alu_op      (dec_alu_op),
        .alu_src_imm (dec_src_imm),
        .op_class    (dec_class)
    );

    assign wait_last = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            wait_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            run_q    <= run_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = wait_q;
        run_d    = 1'b1;
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        opcode_d = bus.instr[OPC_MSB:OPC_LSB];
                        wait_d   = '0;
                        state_d  = ST_DECODE;
                    end else if (wait_last) begin
                        wait_d  = '0;
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_DECODE: state_d = ST_EXEC;
                ST_EXEC: begin
                    case (dec_class)
                        CLS_ALU:         state_d = ST_WB;
                        CLS_LD, CLS_ST:  state_d = ST_MEM;
                        CLS_HALT:        state_d = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        CLS_ILL:         state_d = ST_HALT;
`endif
                        default:         state_d = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        wait_d  = '0;
                        state_d = (dec_class == CLS_LD) ? ST_WB : ST_FETCH;
                    end else if (wait_last) begin
                        wait_d  = '0;
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_WB:   state_d = ST_FETCH;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.dmem_we     = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.alu_src_imm = 1'b0;
        bus.ir_load     = 1'b0;
        bus.reg_we      = 1'b0;
        bus.wb_sel_mem  = 1'b0;
        bus.pc_we       = 1'b0;
        bus.pc_src      = 1'b0;
        bus.halted      = 1'b0;
        bus.timeout     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        bus.illegal     = 1'b0;
`endif
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_load  = bus.imem_ack;
                    // An ack in the last allowed cycle wins over the timeout.
                    bus.timeout  = wait_last & ~bus.imem_ack;
                end
                ST_EXEC: begin
                    bus.alu_op      = dec_alu_op;
                    bus.alu_src_imm = dec_src_imm;
                    case (dec_class)
                        CLS_BEQ: begin bus.pc_we = 1'b1; bus.pc_src = bus.zero;  end
                        CLS_BNE: begin bus.pc_we = 1'b1; bus.pc_src = ~bus.zero; end
                        CLS_JMP: begin bus.pc_we = 1'b1; bus.pc_src = 1'b1;      end
`ifdef CTRL_ILLEGAL_TRAP_EN
                        CLS_ILL: bus.illegal = 1'b1;
`else
                        CLS_ILL: bus.pc_we = 1'b1;
`endif
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    // Address computation stays on the ALU for the transfer.
                    bus.alu_op      = dec_alu_op;
                    bus.alu_src_imm = dec_src_imm;
                    bus.dmem_req    = 1'b1;
                    bus.dmem_we     = (dec_class == CLS_ST);
                    bus.pc_we       = bus.dmem_ack & (dec_class == CLS_ST);
                    bus.timeout     = wait_last & ~bus.dmem_ack;
                end
                ST_WB: begin
                    bus.alu_op      = dec_alu_op;
                    bus.alu_src_imm = dec_src_imm;
                    bus.reg_we      = 1'b1;
                    bus.pc_we       = 1'b1;
                    bus.wb_sel_mem  = (dec_class == CLS_LD);
                end
                ST_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum wait for imem_ack or dmem_ack before a timeout.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr  input  19  instruction word; sampled when ir_load=1.
REQ-005 imem_req/imem_ack  output/input  1/1  instruction-fetch handshake.
REQ-006 dmem_req/dmem_we/dmem_ack  output/output/input  1/1/1  data-memory handshake; dmem_we=1 means store.
REQ-007 zero  input  1  ALU result-is-zero flag.
REQ-008 alu_op  output  4  ALU operation code, 0000 ADD through 0111 SHR.
REQ-009 alu_src_imm  output  1  selects sign-extended imm as ALU operand b.
REQ-010 ir_load, reg_we, wb_sel_mem, pc_we, pc_src  output  1 each  IR load, register write, writeback from memory, PC update, PC source (0 = +1, 1 = target).
REQ-011 halted  output  1  the FSM is in HALT.
REQ-012 timeout  output  1  one-cycle pulse when a handshake wait is abandoned.

Function
REQ-013 Instruction fields: opcode=instr[18:14], rd=[13:10], rs1=[9:6], rs2=[5:2], imm=[9:0].
REQ-014 States: FETCH, DECODE, EXEC, MEM, WB, HALT; HALT is exited only by reset.
REQ-015 FETCH: hold imem_req=1 until imem_ack; on ack, pulse ir_load and go to DECODE.
REQ-016 DECODE always takes exactly one cycle and then goes to EXEC.
REQ-017 Opcodes 0x00–0x07 drive alu_op=opcode[3:0] with alu_src_imm=0; EXEC goes to WB, and WB asserts reg_we=1 and pc_we=1 with pc_src=0.
REQ-018 Opcode 0x08 (ADDI) drives alu_op=0000 with alu_src_imm=1 and otherwise follows the REQ-017 path.
REQ-019 Opcodes 0x10 (LD) and 0x11 (ST) drive alu_op=0000 with alu_src_imm=1; EXEC goes to MEM.
REQ-020 MEM: hold dmem_req=1 until dmem_ack, with dmem_we=1 for ST only.
REQ-021 After the MEM ack, LD goes to WB with reg_we=1 and wb_sel_mem=1; ST pulses pc_we (pc_src=0) and goes to FETCH.
REQ-022 Opcodes 0x12 (BEQ) and 0x13 (BNE) drive alu_op=0001 with alu_src_imm=0; EXEC pulses pc_we and goes to FETCH.
REQ-023 Branch PC source: BEQ uses pc_src=zero; BNE uses pc_src=~zero.
REQ-024 Opcode 0x14 (JMP) pulses pc_we with pc_src=1 in EXEC and goes to FETCH.
REQ-025 Opcode 0x1F (HALT) goes from EXEC to HALT with no pc_we.
REQ-026 reg_we, pc_we, ir_load and timeout are single-cycle pulses.
REQ-027 Outside the states named above, all control outputs are 0 and alu_op=0000.
REQ-028 Latency, ack given in the same cycle as req: ALU op 4 cycles; branch/JMP 3; ST 4; LD 5.
REQ-029 A wait counter counts cycles with req high and no ack, and clears on ack.
REQ-030 If the wait counter reaches TIMEOUT_CYCLES, the FSM pulses timeout, drops req and goes to HALT.
REQ-031 An ack that arrives in the same cycle as the counter reaching TIMEOUT_CYCLES wins: the transfer completes and there is no timeout.
REQ-032 An ack while req=0 is ignored.

Reset
REQ-033 rst_n low asynchronously forces state=FETCH, the wait counter to 0, and all outputs to 0 (alu_op=0000, halted=0).
REQ-034 Reset asserted mid-transfer drops imem_req/dmem_req immediately and aborts the instruction with no reg_we or pc_we.
REQ-035 imem_req rises in the first clock after rst_n deasserts.

Configuration
REQ-036 The trap behaviour for unlisted opcodes is controlled by the macro CTRL_ILLEGAL_TRAP_EN.
REQ-037 With CTRL_ILLEGAL_TRAP_EN defined, an unlisted opcode pulses output illegal (1 bit) in EXEC and goes to HALT.
REQ-038 Without CTRL_ILLEGAL_TRAP_EN, the illegal port is absent and an unlisted opcode acts as a NOP: pc_we (pc_src=0) in EXEC, then FETCH.

Structure
REQ-039 Shared package cpu19_pkg holds the opcode constants, the alu_op encodings, the state enum and the instruction field positions.
REQ-040 Sub-module ctrl_decode is a combinational map from opcode to control word (alu_op, alu_src_imm, class); ctrl_fsm holds the state register and the wait counter.

Verification
REQ-041 Reset, then ADD (0x00) with ack in the same cycle -> ir_load at cycle 1, alu_op=0000 in EXEC, reg_we and pc_we in cycle 4, back in FETCH.
REQ-042 BEQ with zero=1, then BNE with zero=1 -> BEQ gives pc_we with pc_src=1; BNE gives pc_we with pc_src=0; alu_op=0001 for both.
REQ-043 LD with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0, then WB with reg_we=1 and wb_sel_mem=1.
REQ-044 TIMEOUT_CYCLES=4 and imem_ack held low -> timeout pulse after 4 wait cycles, imem_req=0, halted=1; an ack arriving in that same cycle instead completes the fetch.
REQ-045 Opcode 0x1E with the macro defined -> illegal pulse, then halted=1; without the macro -> pc_we with pc_src=0, then FETCH.
REQ-046 rst_n low during the MEM wait -> dmem_req=0 in the same cycle, state FETCH, no reg_we.
